// File: rtl/bp_be_pkg.sv
// Shared back-end constants and writeback request type used by the regfile writeback arbiter.
package bp_be_pkg;

  localparam int num_wb_ports_gp   = 2;
  localparam int reg_addr_width_gp = 5;
  localparam int dword_width_gp    = 64;

  typedef struct packed {
    logic [reg_addr_width_gp-1:0] addr;
    logic [dword_width_gp-1:0]    data;
  } bp_be_wb_req_s;

  // Successor of a requester index in a ring of n entries.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/bp_be_wb_rr_picker.sv
// Combinational two-grant rotating picker. Starved (prio) requesters are scanned first in index order,
// then the rest in rotating order from rr_i; port 1 never takes the same rd as port 0.
module bp_be_wb_rr_picker
  import bp_be_pkg::*;
#(
  parameter int num_req_p = 4,
  localparam int rr_width_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
  input  logic [num_req_p-1:0]                               v_i,
  input  logic [num_req_p-1:0][reg_addr_width_gp-1:0]        addr_i,
  input  logic [rr_width_lp-1:0]                             rr_i,
  input  logic [num_req_p-1:0]                               prio_i,
  output logic [num_wb_ports_gp-1:0][num_req_p-1:0]          grant_o
);

  logic                         found0;
  logic                         found1;
  logic [reg_addr_width_gp-1:0] addr0;
  logic [rr_width_lp-1:0]       idx;
  logic [rr_width_lp:0]         sum;
  logic                         pass;

  // Walk the 2N-slot scan list: slots 0..N-1 are the starved pass, N..2N-1 the rotating pass.
  always_comb begin
    grant_o = '0;
    found0  = 1'b0;
    found1  = 1'b0;
    addr0   = '0;
    idx     = '0;
    sum     = '0;
    pass    = 1'b0;
    for (int k = 0; k < 2*num_req_p; k++) begin
      if (k < num_req_p) begin
        idx  = rr_width_lp'(k);
        pass = prio_i[idx];
      end else begin
        sum  = {1'b0, rr_i} + (rr_width_lp+1)'(k - num_req_p);
        sum  = (sum >= (rr_width_lp+1)'(num_req_p)) ? sum - (rr_width_lp+1)'(num_req_p) : sum;
        idx  = sum[rr_width_lp-1:0];
        pass = ~prio_i[idx];
      end
      if (v_i[idx] && pass) begin
        if (!found0) begin
          grant_o[0][idx] = 1'b1;
          found0          = 1'b1;
          addr0           = addr_i[idx];
        end else if (!found1 && (addr_i[idx] != addr0)) begin
          grant_o[1][idx] = 1'b1;
          found1          = 1'b1;
        end else begin
          found1 = found1;
        end
      end else begin
        found0 = found0;
      end
    end
  end

endmodule

// File: rtl/bp_be_regfile_wb_arbiter.sv
// Shares the two regfile write ports among num_req_p writeback producers, round-robin, registered outputs.
// Optional starvation aging is enabled by defining BP_BE_WB_ARB_AGE_EN.
module bp_be_regfile_wb_arbiter
  import bp_be_pkg::*;
#(
  parameter int num_req_p      = 4,
  parameter int data_width_p   = 64,
  parameter bit zero_x0_p      = 1'b1,
  parameter int starve_limit_p = 8
) (
  input  logic                                              clk_i,
  input  logic                                              reset_i,
  input  logic [num_req_p-1:0]                              req_v_i,
  input  logic [num_req_p-1:0][reg_addr_width_gp-1:0]       req_addr_i,
  input  logic [num_req_p-1:0][data_width_p-1:0]            req_data_i,
  output logic [num_req_p-1:0]                              req_ready_o,
  output logic [num_wb_ports_gp-1:0]                        rd_w_v_o,
  output logic [num_wb_ports_gp-1:0][reg_addr_width_gp-1:0] rd_addr_o,
  output logic [num_wb_ports_gp-1:0][data_width_p-1:0]      rd_data_o
);

  localparam int rr_width_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;

  logic [rr_width_lp-1:0]                          rr_q, rr_d;
  logic [num_wb_ports_gp-1:0]                      rd_w_v_q, rd_w_v_d;
  logic [num_wb_ports_gp-1:0][reg_addr_width_gp-1:0] rd_addr_q, rd_addr_d;
  logic [num_wb_ports_gp-1:0][data_width_p-1:0]    rd_data_q, rd_data_d;

  logic [num_req_p-1:0]                            absorb_s;
  logic [num_req_p-1:0]                            pick_v_s;
  logic [num_req_p-1:0]                            prio_s;
  logic [num_req_p-1:0]                            granted_s;
  logic [num_wb_ports_gp-1:0][num_req_p-1:0]       grant_s;

  // x0 writes are acknowledged immediately and never compete for a port.
  always_comb begin
    absorb_s = '0;
    for (int i = 0; i < num_req_p; i++) begin
      absorb_s[i] = zero_x0_p && req_v_i[i] && (req_addr_i[i] == '0);
    end
  end

  assign pick_v_s  = req_v_i & ~absorb_s;
  assign granted_s = grant_s[0] | grant_s[1];

  bp_be_wb_rr_picker #(.num_req_p(num_req_p)) picker (
    .v_i    (pick_v_s),
    .addr_i (req_addr_i),
    .rr_i   (rr_q),
    .prio_i (prio_s),
    .grant_o(grant_s)
  );

  assign req_ready_o = reset_i ? {num_req_p{1'b0}} : (granted_s | absorb_s);

  // Load write ports from the grants; rr follows the last port-granted requester.
  always_comb begin
    rr_d      = rr_q;
    rd_w_v_d  = '0;
    rd_addr_d = '0;
    rd_data_d = '0;
    for (int p = 0; p < num_wb_ports_gp; p++) begin
      for (int i = 0; i < num_req_p; i++) begin
        if (grant_s[p][i]) begin
          rd_w_v_d[p]  = 1'b1;
          rd_addr_d[p] = req_addr_i[i];
          rd_data_d[p] = req_data_i[i];
          rr_d         = rr_width_lp'(wrap_inc(i, num_req_p));
        end else begin
          rd_w_v_d[p] = rd_w_v_d[p];
        end
      end
    end
  end

  // Port and rotation state.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_q      <= '0;
      rd_w_v_q  <= '0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      rr_q      <= rr_d;
      rd_w_v_q  <= rd_w_v_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_w_v_o  = rd_w_v_q;
  assign rd_addr_o = rd_addr_q;
  assign rd_data_o = rd_data_q;

`ifdef BP_BE_WB_ARB_AGE_EN
  localparam int age_width_lp = $clog2(starve_limit_p + 1);
  localparam logic [age_width_lp-1:0] age_max_lp = age_width_lp'(starve_limit_p);

  logic [num_req_p-1:0][age_width_lp-1:0] age_q, age_d;

  // Saturating wait counters; a requester at the limit is promoted into the starved pass.
  always_comb begin
    age_d  = age_q;
    prio_s = '0;
    for (int i = 0; i < num_req_p; i++) begin
      prio_s[i] = (age_q[i] == age_max_lp);
      if (granted_s[i]) begin
        age_d[i] = '0;
      end else if (req_v_i[i] && !absorb_s[i] && (age_q[i] != age_max_lp)) begin
        age_d[i] = age_q[i] + age_width_lp'(1);
      end else begin
        age_d[i] = age_q[i];
      end
    end
  end

  // Wait counter state.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      age_q <= '0;
    end else begin
      age_q <= age_d;
    end
  end
`else
  localparam int unused_starve_limit_lp = starve_limit_p;
  assign prio_s = '0;
`endif

endmodule

// File: tb/tb_bp_be_regfile_wb_arbiter.sv
// Self-checking bench for bp_be_regfile_wb_arbiter: directed scenarios plus randomized traffic vs a scan-list model.
module tb_bp_be_regfile_wb_arbiter;

  localparam int N      = 4;
  localparam int DW     = 64;
  localparam int STARVE = 2;

  logic                 clk = 1'b0;
  logic                 reset_i;
  logic [N-1:0]         req_v_i;
  logic [N-1:0][4:0]    req_addr_i;
  logic [N-1:0][DW-1:0] req_data_i;
  logic [N-1:0]         req_ready_o;
  logic [1:0]           rd_w_v_o;
  logic [1:0][4:0]      rd_addr_o;
  logic [1:0][DW-1:0]   rd_data_o;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int          m_rr;
  logic [1:0]  m_wv;
  logic [4:0]  m_addr [2];
  logic [63:0] m_data [2];
  int          m_age  [N];
  logic [N-1:0] m_ready;
  int          m_g0, m_g1;

  always #5 clk = ~clk;

  bp_be_regfile_wb_arbiter #(
    .num_req_p(N), .data_width_p(DW), .zero_x0_p(1'b1), .starve_limit_p(STARVE)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .req_v_i(req_v_i), .req_addr_i(req_addr_i),
    .req_data_i(req_data_i), .req_ready_o(req_ready_o), .rd_w_v_o(rd_w_v_o),
    .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o)
  );

  // Build the scan list (starved first, then rotation from rr) and walk it.
  task automatic model_eval();
    int order [2*N];
    int cnt = 0;
    bit starved [N];
    m_ready = '0; m_g0 = -1; m_g1 = -1;
    if (reset_i) return;
    for (int i = 0; i < N; i++) begin
      starved[i] = 1'b0;
`ifdef BP_BE_WB_ARB_AGE_EN
      if (m_age[i] >= STARVE) begin starved[i] = 1'b1; order[cnt] = i; cnt++; end
`endif
    end
    for (int k = 0; k < N; k++) begin
      int i = (m_rr + k) % N;
      if (!starved[i]) begin order[cnt] = i; cnt++; end
    end
    for (int s = 0; s < cnt; s++) begin
      int i = order[s];
      if (!req_v_i[i]) continue;
      if (req_addr_i[i] == 5'd0) begin m_ready[i] = 1'b1; continue; end
      if (m_g0 < 0) begin m_g0 = i; m_ready[i] = 1'b1; end
      else if (m_g1 < 0 && req_addr_i[i] != req_addr_i[m_g0]) begin m_g1 = i; m_ready[i] = 1'b1; end
    end
  endtask

  task automatic model_commit();
    if (reset_i) begin
      m_rr = 0; m_wv = 2'b00;
      for (int i = 0; i < N; i++) m_age[i] = 0;
      return;
    end
    m_wv = {m_g1 >= 0, m_g0 >= 0};
    if (m_g0 >= 0) begin m_addr[0] = req_addr_i[m_g0]; m_data[0] = req_data_i[m_g0]; m_rr = (m_g0 + 1) % N; end
    if (m_g1 >= 0) begin m_addr[1] = req_addr_i[m_g1]; m_data[1] = req_data_i[m_g1]; m_rr = (m_g1 + 1) % N; end
    for (int i = 0; i < N; i++) begin
      if (i == m_g0 || i == m_g1) m_age[i] = 0;
      else if (req_v_i[i] && !m_ready[i] && m_age[i] < STARVE) m_age[i]++;
    end
  endtask

  task automatic eval_cycle();
    @(negedge clk);
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1; req_v_i = '0;
    eval_cycle(); tick();
    reset_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1; req_v_i = '1;
    for (int i = 0; i < N; i++) begin req_addr_i[i] = 5'(i + 1); req_data_i[i] = 64'(i); end
    eval_cycle();
    n_checks++;
    if (req_ready_o !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b expected 0000", req_ready_o); end
    tick();
    n_checks++;
    if (rd_w_v_o !== 2'b00 || rd_addr_o !== 10'd0 || rd_data_o !== 128'd0) begin
      n_fail++; $display("FAIL reset_outputs: got v=%b addr=%h data=%h expected all zero", rd_w_v_o, rd_addr_o, rd_data_o);
    end
    reset_i = 1'b0; req_v_i = '0;
  endtask

  task automatic test_single();
    do_reset();
    req_v_i = 4'b0001; req_addr_i[0] = 5'd5; req_data_i[0] = 64'hA;
    eval_cycle();
    n_checks++;
    if (req_ready_o !== 4'b0001) begin n_fail++; $display("FAIL single_ready: got %b expected 0001", req_ready_o); end
    tick(); req_v_i = '0;
    n_checks++;
    if (rd_w_v_o !== 2'b01 || rd_addr_o[0] !== 5'd5 || rd_data_o[0] !== 64'hA) begin
      n_fail++; $display("FAIL single_write: got v=%b a=%0d d=%h expected v=01 a=5 d=a", rd_w_v_o, rd_addr_o[0], rd_data_o[0]);
    end
    eval_cycle(); tick();
    n_checks++;
    if (rd_w_v_o !== 2'b00) begin n_fail++; $display("FAIL single_idle: got v=%b expected 00", rd_w_v_o); end
  endtask

  task automatic test_rr_three();
    do_reset();
    req_v_i = 4'b0111;
    for (int i = 0; i < 3; i++) begin req_addr_i[i] = 5'(i + 1); req_data_i[i] = 64'(16 + i); end
    eval_cycle();
    n_checks++;
    if (req_ready_o !== 4'b0011) begin n_fail++; $display("FAIL rr3_ready_n: got %b expected 0011", req_ready_o); end
    tick(); req_v_i = 4'b0100;
    n_checks++;
    if (rd_w_v_o !== 2'b11 || rd_addr_o[0] !== 5'd1 || rd_addr_o[1] !== 5'd2 || rd_data_o[1] !== 64'd17) begin
      n_fail++; $display("FAIL rr3_write_n: got v=%b a0=%0d a1=%0d d1=%0d expected v=11 a0=1 a1=2 d1=17",
                         rd_w_v_o, rd_addr_o[0], rd_addr_o[1], rd_data_o[1]);
    end
    eval_cycle();
    n_checks++;
    if (req_ready_o !== 4'b0100) begin n_fail++; $display("FAIL rr3_ready_n1: got %b expected 0100", req_ready_o); end
    tick(); req_v_i = '0;
    n_checks++;
    if (rd_w_v_o !== 2'b01 || rd_addr_o[0] !== 5'd3 || rd_data_o[0] !== 64'd18) begin
      n_fail++; $display("FAIL rr3_write_n1: got v=%b a0=%0d d0=%0d expected v=01 a0=3 d0=18", rd_w_v_o, rd_addr_o[0], rd_data_o[0]);
    end
    // rr now 3: a lone req1 and req3 scan 3 first
    req_v_i = 4'b1010; req_addr_i[1] = 5'd6; req_addr_i[3] = 5'd6;
    eval_cycle();
    n_checks++;
    if (req_ready_o !== 4'b1000) begin n_fail++; $display("FAIL rr3_wrap: got %b expected 1000", req_ready_o); end
    tick(); req_v_i = 4'b0010;
    eval_cycle(); tick(); req_v_i = '0;
  endtask

  task automatic test_same_rd();
    do_reset();
    req_v_i = 4'b0011; req_addr_i[0] = 5'd7; req_addr_i[1] = 5'd7;
    req_data_i[0] = 64'h11; req_data_i[1] = 64'h22;
    eval_cycle();
    n_checks++;
    if (req_ready_o !== 4'b0001) begin n_fail++; $display("FAIL samerd_ready_n: got %b expected 0001", req_ready_o); end
    tick(); req_v_i = 4'b0010;
    n_checks++;
    if (rd_w_v_o !== 2'b01 || rd_addr_o[0] !== 5'd7 || rd_data_o[0] !== 64'h11) begin
      n_fail++; $display("FAIL samerd_write_n1: got v=%b a=%0d d=%h expected v=01 a=7 d=11", rd_w_v_o, rd_addr_o[0], rd_data_o[0]);
    end
    eval_cycle();
    n_checks++;
    if (req_ready_o !== 4'b0010) begin n_fail++; $display("FAIL samerd_ready_n1: got %b expected 0010", req_ready_o); end
    tick(); req_v_i = '0;
    n_checks++;
    if (rd_w_v_o !== 2'b01 || rd_addr_o[0] !== 5'd7 || rd_data_o[0] !== 64'h22) begin
      n_fail++; $display("FAIL samerd_write_n2: got v=%b a=%0d d=%h expected v=01 a=7 d=22", rd_w_v_o, rd_addr_o[0], rd_data_o[0]);
    end
  endtask

  task automatic test_x0();
    do_reset();
    req_v_i = 4'b1100; req_addr_i[2] = 5'd0; req_addr_i[3] = 5'd4;
    req_data_i[2] = 64'h99; req_data_i[3] = 64'h44;
    eval_cycle();
    n_checks++;
    if (req_ready_o !== 4'b1100) begin n_fail++; $display("FAIL x0_ready: got %b expected 1100", req_ready_o); end
    tick(); req_v_i = '0;
    n_checks++;
    if (rd_w_v_o !== 2'b01 || rd_addr_o[0] !== 5'd4 || rd_data_o[0] !== 64'h44) begin
      n_fail++; $display("FAIL x0_write: got v=%b a=%0d d=%h expected v=01 a=4 d=44", rd_w_v_o, rd_addr_o[0], rd_data_o[0]);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_v_i = '1;
    for (int i = 0; i < N; i++) begin req_addr_i[i] = 5'(i + 1); req_data_i[i] = 64'(32 + i); end
    eval_cycle(); tick();
    reset_i = 1'b1;
    eval_cycle();
    n_checks++;
    if (req_ready_o !== 4'b0000) begin n_fail++; $display("FAIL mid_reset_ready: got %b expected 0000", req_ready_o); end
    tick(); reset_i = 1'b0;
    n_checks++;
    if (rd_w_v_o !== 2'b00) begin n_fail++; $display("FAIL mid_reset_out: got v=%b expected 00", rd_w_v_o); end
    eval_cycle();
    n_checks++;
    if (req_ready_o !== 4'b0011) begin n_fail++; $display("FAIL mid_reset_resume: got %b expected 0011", req_ready_o); end
    tick(); req_v_i = '0;
    n_checks++;
    if (rd_w_v_o !== 2'b11 || rd_addr_o[0] !== 5'd1 || rd_addr_o[1] !== 5'd2) begin
      n_fail++; $display("FAIL mid_reset_write: got v=%b a0=%0d a1=%0d expected v=11 a0=1 a1=2", rd_w_v_o, rd_addr_o[0], rd_addr_o[1]);
    end
  endtask

`ifdef BP_BE_WB_ARB_AGE_EN
  task automatic test_age();
    do_reset();
    req_v_i = 4'b1110;
    for (int i = 1; i < N; i++) begin req_addr_i[i] = 5'd9; req_data_i[i] = 64'(i); end
    eval_cycle();
    n_checks++;
    if (req_ready_o !== 4'b0010) begin n_fail++; $display("FAIL age_c0: got %b expected 0010", req_ready_o); end
    tick();
    eval_cycle();
    n_checks++;
    if (req_ready_o !== 4'b0100) begin n_fail++; $display("FAIL age_c1: got %b expected 0100", req_ready_o); end
    tick();
    eval_cycle();
    n_checks++;
    if (req_ready_o !== 4'b1000) begin n_fail++; $display("FAIL age_starved: got %b expected 1000", req_ready_o); end
    tick(); req_v_i = '0;
    n_checks++;
    if (rd_w_v_o !== 2'b01 || rd_data_o[0] !== 64'd3) begin
      n_fail++; $display("FAIL age_write: got v=%b d=%0d expected v=01 d=3", rd_w_v_o, rd_data_o[0]);
    end
  endtask
`endif

  task automatic test_random();
    do_reset();
    req_v_i = '0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_v_i[i] && $urandom_range(0, 99) < 60) begin
          req_v_i[i] = 1'b1;
          req_addr_i[i] = 5'($urandom_range(0, 7));
          req_data_i[i] = {$urandom, $urandom};
        end
      end
      reset_i = ($urandom_range(0, 49) == 0);
      eval_cycle();
      n_checks++;
      if (req_ready_o !== m_ready) begin
        n_fail++; $display("FAIL rand_ready c=%0d: got %b expected %b", c, req_ready_o, m_ready);
      end
      tick();
      for (int i = 0; i < N; i++) if (m_ready[i]) req_v_i[i] = 1'b0;
      n_checks++;
      if (rd_w_v_o !== m_wv) begin
        n_fail++; $display("FAIL rand_wv c=%0d: got %b expected %b", c, rd_w_v_o, m_wv);
      end
      for (int p = 0; p < 2; p++) begin
        if (m_wv[p]) begin
          n_checks++;
          if (rd_addr_o[p] !== m_addr[p] || rd_data_o[p] !== m_data[p]) begin
            n_fail++; $display("FAIL rand_port%0d c=%0d: got a=%0d d=%h expected a=%0d d=%h",
                               p, c, rd_addr_o[p], rd_data_o[p], m_addr[p], m_data[p]);
          end
        end
      end
    end
    reset_i = 1'b0; req_v_i = '0;
  endtask

  initial begin
    reset_i = 1'b0; req_v_i = '0; req_addr_i = '0; req_data_i = '0;
    m_rr = 0; m_wv = 2'b00; m_ready = '0; m_g0 = -1; m_g1 = -1;
    for (int i = 0; i < N; i++) m_age[i] = 0;
    for (int p = 0; p < 2; p++) begin m_addr[p] = '0; m_data[p] = '0; end
    #2;
    test_reset();
    test_single();
    test_rr_three();
    test_same_rd();
    test_x0();
    test_reset_mid();
`ifdef BP_BE_WB_ARB_AGE_EN
    test_age();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
